// File: rtl/alarm_timer_unit_pkg.sv
// Shared definitions for the alarm timer datapath: default intervals, BCD time
// types and the alarm-match compare used by the status logic.
package alarm_timer_unit_pkg;

    localparam int BCD_W           = 8;
    localparam int DEF_SOUND_SECS  = 60;
    localparam int DEF_SNOOZE_SECS = 300;
    localparam int DEF_CNT_W       = 9;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_ZERO = '0;

    typedef struct packed {
        bcd_t hh;
        bcd_t mm;
        bcd_t ss;
    } bcd_time_t;

    // Raw BCD equality; the alarm fires only at second zero of the matching minute.
    function automatic logic time_match(input bcd_time_t cur, input bcd_t alm_hh,
                                        input bcd_t alm_mm);
        return (cur.hh == alm_hh) && (cur.mm == alm_mm) && (cur.ss == BCD_ZERO);
    endfunction

endpackage

// File: rtl/alarm_timer_unit_if.sv
// Handshake between the alarm control unit (master) and this timer unit (slave):
// state outputs of the control unit in one direction, status flags in the other.
interface alarm_timer_unit_if;

    logic Sound;
    logic EN_SNZ;
    logic EN_STOP;
    logic AA;
    logic C0;
    logic CS0;

    modport master (
        output Sound, EN_SNZ, EN_STOP,
        input  AA, C0, CS0
    );

    modport slave (
        input  Sound, EN_SNZ, EN_STOP,
        output AA, C0, CS0
    );

endinterface

// File: rtl/expiry_counter.sv
// Saturating 1 Hz down-counter: loads LOAD_VAL when Run rises, counts Ticks while
// Run and Qual are high, and flags Done once it has reached zero.
module expiry_counter #(
    parameter int LOAD_VAL = 60,
    parameter int CNT_W    = 9
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Tick,
    input  logic Run,
    input  logic Qual,
    output logic Done
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOAD_VAL);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             act;
    logic             idle_q;

    // idle_q means "Run was seen low on the previous edge". Reset clears it, so a
    // Run level held through reset does not reload until it falls and rises again.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt    <= '0;
            act    <= 1'b0;
            idle_q <= 1'b0;
        end else begin
            idle_q <= ~Run;
            if (!Run) begin
                cnt <= '0;
                act <= 1'b0;
            end else if (idle_q) begin
                cnt <= LOAD;
                act <= 1'b1;
            end else if (act && Qual && Tick && (cnt != '0)) begin
                cnt <= cnt - ONE;
            end
        end
    end

    assign Done = act && (cnt == '0);

endmodule

// File: rtl/alarm_timer_unit.sv
// Status side of the alarm controller: alarm-time match pulse (AA) plus the ring
// (C0) and snooze (CS0) expiry counters driven by the control unit's state outputs.
module alarm_timer_unit
    import alarm_timer_unit_pkg::*;
#(
    parameter int SOUND_SECS  = DEF_SOUND_SECS,
    parameter int SNOOZE_SECS = DEF_SNOOZE_SECS,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Tick,
    input  bcd_t Cur_HH,
    input  bcd_t Cur_MM,
    input  bcd_t Cur_SS,
    input  bcd_t Alm_HH,
    input  bcd_t Alm_MM,
    input  logic Alarm_On,
    alarm_timer_unit_if.slave hs
);

    bcd_time_t cur;
    logic      match;
    logic      match_q;
    logic      aa_q;

    assign cur   = '{hh: Cur_HH, mm: Cur_MM, ss: Cur_SS};
    assign match = Alarm_On && time_match(cur, Alm_HH, Alm_MM);

    // Registered rising-edge detect: one AA pulse per matching second.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            match_q <= 1'b0;
            aa_q    <= 1'b0;
        end else begin
            match_q <= match;
            aa_q    <= match && !match_q;
        end
    end

    assign hs.AA = aa_q;

    expiry_counter #(
        .LOAD_VAL (SOUND_SECS),
        .CNT_W    (CNT_W)
    ) u_ring (
        .Clk   (Clk),
        .Reset (Reset),
        .Tick  (Tick),
        .Run   (hs.Sound),
        .Qual  (hs.EN_STOP),
        .Done  (hs.C0)
    );

    expiry_counter #(
        .LOAD_VAL (SNOOZE_SECS),
        .CNT_W    (CNT_W)
    ) u_snooze (
        .Clk   (Clk),
        .Reset (Reset),
        .Tick  (Tick),
        .Run   (hs.EN_SNZ),
        .Qual  (1'b1),
        .Done  (hs.CS0)
    );

endmodule

// File: tb/tb_alarm_timer_unit.sv
// Directed bench for alarm_timer_unit with SOUND_SECS=4, SNOOZE_SECS=3.
module tb_alarm_timer_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Tick;
    logic [7:0] Cur_HH, Cur_MM, Cur_SS;
    logic [7:0] Alm_HH, Alm_MM;
    logic       Alarm_On;

    int total = 0;
    int bad   = 0;

    alarm_timer_unit_if itf ();

    alarm_timer_unit #(
        .SOUND_SECS  (4),
        .SNOOZE_SECS (3),
        .CNT_W       (9)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Tick     (Tick),
        .Cur_HH   (Cur_HH),
        .Cur_MM   (Cur_MM),
        .Cur_SS   (Cur_SS),
        .Alm_HH   (Alm_HH),
        .Alm_MM   (Alm_MM),
        .Alarm_On (Alarm_On),
        .hs       (itf.slave)
    );

    always #5 Clk = ~Clk;

    // Inputs change at a falling edge, the DUT samples them at the next rising
    // edge, and outputs are observed at the following falling edge.
    task automatic cyc(input logic tk);
        Tick = tk;
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        Cur_HH = hh;
        Cur_MM = mm;
        Cur_SS = ss;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        itf.Sound = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        total++; if (itf.AA !== 1'b0) begin bad++; $display("FAIL reset_aa got=%b want=0", itf.AA); end
        total++; if (itf.C0 !== 1'b0) begin bad++; $display("FAIL reset_c0 got=%b want=0", itf.C0); end
        total++; if (itf.CS0 !== 1'b0) begin bad++; $display("FAIL reset_cs0 got=%b want=0", itf.CS0); end
        total++; if (dut.u_ring.cnt !== 9'd0) begin bad++; $display("FAIL reset_snd_cnt got=%0d want=0", dut.u_ring.cnt); end
        total++; if (dut.u_snooze.cnt !== 9'd0) begin bad++; $display("FAIL reset_snz_cnt got=%0d want=0", dut.u_snooze.cnt); end
        Reset = 1'b1;
        cyc(1'b0);
        total++; if (dut.u_ring.cnt !== 9'd0) begin bad++; $display("FAIL reset_held_sound got=%0d want=0", dut.u_ring.cnt); end
        itf.Sound = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_match;
        int hits;
        Alm_HH = 8'h07;
        Alm_MM = 8'h30;
        Alarm_On = 1'b1;
        set_time(8'h07, 8'h29, 8'h59);
        cyc(1'b1);
        total++; if (itf.AA !== 1'b0) begin bad++; $display("FAIL match_before got=%b want=0", itf.AA); end
        set_time(8'h07, 8'h30, 8'h00);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            if (i == 0) begin
                total++; if (itf.AA !== 1'b1) begin bad++; $display("FAIL match_first got=%b want=1", itf.AA); end
            end
            if (itf.AA === 1'b1) hits++;
        end
        total++; if (hits != 1) begin bad++; $display("FAIL match_pulse_count got=%0d want=1", hits); end
        set_time(8'h07, 8'h30, 8'h01);
        cyc(1'b1);

        // Minute mismatch at second zero must not fire.
        set_time(8'h07, 8'h31, 8'h00);
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            if (itf.AA === 1'b1) hits++;
        end
        total++; if (hits != 0) begin bad++; $display("FAIL match_wrong_minute got=%0d want=0", hits); end

        Alarm_On = 1'b0;
        set_time(8'h07, 8'h29, 8'h59);
        cyc(1'b0);
        set_time(8'h07, 8'h30, 8'h00);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0);
            if (itf.AA === 1'b1) hits++;
        end
        total++; if (hits != 0) begin bad++; $display("FAIL match_disarmed got=%0d want=0", hits); end

        // Time already matching across reset release still fires once.
        Alarm_On = 1'b1;
        Reset = 1'b0;
        cyc(1'b0);
        total++; if (itf.AA !== 1'b0) begin bad++; $display("FAIL match_in_reset got=%b want=0", itf.AA); end
        Reset = 1'b1;
        cyc(1'b0);
        total++; if (itf.AA !== 1'b1) begin bad++; $display("FAIL match_at_release got=%b want=1", itf.AA); end
        cyc(1'b0);
        total++; if (itf.AA !== 1'b0) begin bad++; $display("FAIL match_release_drop got=%b want=0", itf.AA); end
        Alarm_On = 1'b0;
        set_time(8'h12, 8'h00, 8'h05);
        cyc(1'b0);
    endtask

    task automatic test_ring;
        itf.EN_STOP = 1'b1;
        itf.Sound = 1'b1;
        cyc(1'b0);
        total++; if (dut.u_ring.cnt !== 9'd4) begin bad++; $display("FAIL ring_load got=%0d want=4", dut.u_ring.cnt); end
        total++; if (itf.C0 !== 1'b0) begin bad++; $display("FAIL ring_load_c0 got=%b want=0", itf.C0); end
        cyc(1'b1);
        cyc(1'b1);
        total++; if (dut.u_ring.cnt !== 9'd2) begin bad++; $display("FAIL ring_two_ticks got=%0d want=2", dut.u_ring.cnt); end
        itf.EN_STOP = 1'b0;
        cyc(1'b1);
        total++; if (dut.u_ring.cnt !== 9'd2) begin bad++; $display("FAIL ring_frozen got=%0d want=2", dut.u_ring.cnt); end
        itf.EN_STOP = 1'b1;
        cyc(1'b1);
        total++; if (itf.C0 !== 1'b0) begin bad++; $display("FAIL ring_third_tick got=%b want=0", itf.C0); end
        cyc(1'b1);
        total++; if (itf.C0 !== 1'b1) begin bad++; $display("FAIL ring_fourth_tick got=%b want=1", itf.C0); end
        cyc(1'b1);
        cyc(1'b0);
        total++; if (itf.C0 !== 1'b1) begin bad++; $display("FAIL ring_hold got=%b want=1", itf.C0); end
        total++; if (dut.u_ring.cnt !== 9'd0) begin bad++; $display("FAIL ring_saturate got=%0d want=0", dut.u_ring.cnt); end
        itf.Sound = 1'b0;
        cyc(1'b0);
        total++; if (itf.C0 !== 1'b0) begin bad++; $display("FAIL ring_drop got=%b want=0", itf.C0); end
    endtask

    task automatic test_collision;
        itf.EN_SNZ = 1'b1;
        cyc(1'b1);
        total++; if (dut.u_snooze.cnt !== 9'd3) begin bad++; $display("FAIL coll_load got=%0d want=3", dut.u_snooze.cnt); end
        cyc(1'b1);
        cyc(1'b1);
        total++; if (itf.CS0 !== 1'b0) begin bad++; $display("FAIL coll_two_ticks got=%b want=0", itf.CS0); end
        cyc(1'b1);
        total++; if (itf.CS0 !== 1'b1) begin bad++; $display("FAIL coll_three_ticks got=%b want=1", itf.CS0); end
        itf.EN_SNZ = 1'b0;
        cyc(1'b0);
        total++; if (itf.CS0 !== 1'b0) begin bad++; $display("FAIL coll_drop got=%b want=0", itf.CS0); end
    endtask

    task automatic test_abort;
        int c0_seen;
        itf.EN_STOP = 1'b1;
        itf.Sound = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        total++; if (dut.u_ring.cnt !== 9'd2) begin bad++; $display("FAIL abort_pre got=%0d want=2", dut.u_ring.cnt); end
        itf.Sound = 1'b0;
        c0_seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            if (itf.C0 === 1'b1) c0_seen++;
        end
        total++; if (c0_seen != 0) begin bad++; $display("FAIL abort_no_c0 got=%0d want=0", c0_seen); end
        total++; if (dut.u_ring.cnt !== 9'd0) begin bad++; $display("FAIL abort_clear got=%0d want=0", dut.u_ring.cnt); end
        itf.Sound = 1'b1;
        cyc(1'b0);
        total++; if (dut.u_ring.cnt !== 9'd4) begin bad++; $display("FAIL abort_reload got=%0d want=4", dut.u_ring.cnt); end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        total++; if (itf.C0 !== 1'b0) begin bad++; $display("FAIL abort_three got=%b want=0", itf.C0); end
        cyc(1'b1);
        total++; if (itf.C0 !== 1'b1) begin bad++; $display("FAIL abort_four got=%b want=1", itf.C0); end
        itf.Sound = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_reset_mid_snooze;
        itf.EN_SNZ = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        total++; if (dut.u_snooze.cnt !== 9'd1) begin bad++; $display("FAIL rst_snz_pre got=%0d want=1", dut.u_snooze.cnt); end
        Reset = 1'b0;
        cyc(1'b1);
        total++; if (itf.CS0 !== 1'b0) begin bad++; $display("FAIL rst_snz_cs0 got=%b want=0", itf.CS0); end
        total++; if (dut.u_snooze.cnt !== 9'd0) begin bad++; $display("FAIL rst_snz_cnt got=%0d want=0", dut.u_snooze.cnt); end
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1);
        total++; if (dut.u_snooze.cnt !== 9'd0) begin bad++; $display("FAIL rst_snz_noreload got=%0d want=0", dut.u_snooze.cnt); end
        total++; if (itf.CS0 !== 1'b0) begin bad++; $display("FAIL rst_snz_idle_cs0 got=%b want=0", itf.CS0); end
        itf.EN_SNZ = 1'b0;
        cyc(1'b0);
        itf.EN_SNZ = 1'b1;
        cyc(1'b0);
        total++; if (dut.u_snooze.cnt !== 9'd3) begin bad++; $display("FAIL rst_snz_reload got=%0d want=3", dut.u_snooze.cnt); end
        for (int i = 0; i < 3; i++) cyc(1'b1);
        total++; if (itf.CS0 !== 1'b1) begin bad++; $display("FAIL rst_snz_expire got=%b want=1", itf.CS0); end
        itf.EN_SNZ = 1'b0;
        cyc(1'b0);
    endtask

    initial begin
        Reset = 1'b0;
        Tick = 1'b0;
        Alarm_On = 1'b0;
        Alm_HH = 8'h07;
        Alm_MM = 8'h30;
        set_time(8'h00, 8'h00, 8'h01);
        itf.Sound = 1'b0;
        itf.EN_SNZ = 1'b0;
        itf.EN_STOP = 1'b0;
        @(negedge Clk);
        test_reset;
        test_match;
        test_ring;
        test_collision;
        test_abort;
        test_reset_mid_snooze;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
